dmem_arbiter: RTL

//  Shares the single-port data memory between two requesters: port 0 (CPU
//  MEM stage) and port 1 (loader/debug master). Per-cycle arbitration with
//  req/gnt handshake, round-robin or fixed priority, optional port-1 bus

---
 rtl/dmem_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory.
// Port 0 is the CPU MEM stage, port 1 the loader/debug master. Grants are
// combinational per cycle; read data is registered with a one-cycle rvalid.
// Port 1 may lock the bus, bounded by LOCK_MAX so port 0 cannot starve.
module dmem_arbiter #(
  parameter int AW          = 32,
  parameter int ROUND_ROBIN = 1,
  parameter int LOCK_MAX    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [31:0]   p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [31:0]   p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [31:0]   p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [31:0]   p1_rdata,
  input  logic          p1_lock,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [31:0]   mem_wd,
  input  logic [31:0]   mem_rd
);

  typedef enum logic {IDLE, LOCK1} state_t;

  localparam int CW = $clog2(LOCK_MAX) + 1;

  state_t        state, state_nxt;
  logic [CW-1:0] lock_cnt, lock_cnt_nxt;
  logic          last, last_nxt;
  logic          rd0_acc, rd1_acc;

  // Byte-lane bits of the request addresses play no part in word access.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{p0_addr[1:0], p1_addr[1:0]};

  // Arbitration state: FSM state, lock cycle counter and last granted port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      lock_cnt <= '0;
      last     <= 1'b1;
    end else begin
      state    <= state_nxt;
      lock_cnt <= lock_cnt_nxt;
      last     <= last_nxt;
    end
  end

  // Grant selection and next-state logic; gnt is only ever raised with req.
  always_comb begin
    state_nxt    = state;
    lock_cnt_nxt = lock_cnt;
    last_nxt     = last;
    p0_gnt       = 1'b0;
    p1_gnt       = 1'b0;
    case (state)
      IDLE: begin
        lock_cnt_nxt = '0;
        if (p0_req && p1_req) begin
          // last == 1 means port 1 was served last, so port 0 wins the tie.
          if ((ROUND_ROBIN != 0) && !last) p1_gnt = 1'b1;
          else                             p0_gnt = 1'b1;
        end else if (p0_req) begin
          p0_gnt = 1'b1;
        end else if (p1_req) begin
          p1_gnt = 1'b1;
        end
        if (p0_gnt) last_nxt = 1'b0;
        if (p1_gnt) begin
          last_nxt = 1'b1;
          if (p1_lock) begin
            state_nxt    = LOCK1;
            lock_cnt_nxt = CW'(1);
          end
        end
      end
      LOCK1: begin
        p1_gnt       = p1_req;
        lock_cnt_nxt = lock_cnt + CW'(1);
        // Leaving the lock hands the next tie to port 0; re-locking needs
        // a fresh accept from IDLE.
        if (!p1_lock || (lock_cnt == CW'(LOCK_MAX - 1))) begin
          state_nxt    = IDLE;
          last_nxt     = 1'b1;
          lock_cnt_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rd0_acc = p0_gnt && !p0_we;
  assign rd1_acc = p1_gnt && !p1_we;

  // Memory-side mux: port 0 drives the bus whenever port 1 is not granted.
  assign mem_we = (p0_gnt && p0_we) || (p1_gnt && p1_we);
  assign mem_a  = p1_gnt ? {p1_addr[AW-1:2], 2'b00} : {p0_addr[AW-1:2], 2'b00};
  assign mem_wd = p1_gnt ? p1_wdata : p0_wdata;

  // Registered read return: capture mem_rd at the end of each read accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
    end else begin
      p0_rvalid <= rd0_acc;
      p1_rvalid <= rd1_acc;
      if (rd0_acc) p0_rdata <= mem_rd;
      if (rd1_acc) p1_rdata <= mem_rd;
    end
  end

endmodule
